// File: rtl/wb_stage_reg.sv
// wb_stage_reg: registered writeback stage between MEM and the register file.
//
// Extracts and extends sub-word loads (XLEN 32 or 64). It holds the MEM stage through a
// wait state while a data-memory response is outstanding. It honours flush and drives a
// forwarding tap.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   mem_valid_i          MEM presents an instruction
//   mem_opcode_i         opcode; mem_funct3_i is the load size/sign selector
//   mem_rd_i             destination register
//   mem_res_i            ALU result, or the effective address for loads
//   mem_pc_i             instruction PC
//   flush_i              kills the incoming instruction and any pending load
//   d_data_read, d_ack   data-memory read word and its valid strobe
//   wb_stall_o           MEM must hold its instruction
//   rf_we_o, rf_waddr_o, rf_wdata_o   registered write port
//   misalign_o           pulse when a misaligned load is dropped
//   fwd_valid_o, fwd_rd_o, fwd_data_o  copies of the rf_* outputs
module wb_stage_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid_i,
  input  logic [6:0]        mem_opcode_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_res_i,
  input  logic [XLEN-1:0]   mem_pc_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   d_data_read,
  input  logic              d_ack,
  output logic              wb_stall_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              misalign_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_rd_o,
  output logic [XLEN-1:0]   fwd_data_o
);

  localparam int unsigned OffW = $clog2(XLEN / 8);

  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  localparam logic [XLEN-1:0] PcStep = 4;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // One retired instruction on its way to the write port.
  typedef struct packed {
    logic              we;
    logic              mis;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } item_t;

  // Returns {misaligned, extended value}.
  function automatic logic [XLEN:0] load_extract(input logic [XLEN-1:0] data,
                                                 input logic [OffW-1:0] off,
                                                 input logic [2:0]      funct3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] val;
    logic            mis;
    logic [2:0]      f;
    sh = data >> {off, 3'b000};
    f  = funct3;
    // Fold unsupported/reserved encodings onto the widest legal load.
    if (XLEN == 32) begin
      if (f == 3'b011 || f == 3'b110 || f == 3'b111) f = 3'b010;
    end else if (f == 3'b111) begin
      f = 3'b011;
    end
    mis = 1'b0;
    val = sh;
    case (f)
      3'b000, 3'b100: begin
        val      = {XLEN{sh[7] & ~f[2]}};
        val[7:0] = sh[7:0];
      end
      3'b001, 3'b101: begin
        mis       = off[0];
        val       = {XLEN{sh[15] & ~f[2]}};
        val[15:0] = sh[15:0];
      end
      3'b010, 3'b110: begin
        mis       = |off[1:0];
        val       = {XLEN{sh[31] & ~f[2]}};
        val[31:0] = sh[31:0];
      end
      default: begin
        mis = |off;
        val = sh;
      end
    endcase
    return {mis, val};
  endfunction

  state_e            state_q, state_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [OffW-1:0]   ld_off_q, ld_off_d;
  item_t             skid_q, skid_d;
  logic              skid_v_q, skid_v_d;
  logic              rf_we_q, rf_we_d;
  logic              misalign_q, misalign_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic              stall;
  logic              accept;
  logic              is_load;
  logic              load_defer;
  logic              acc_v;
  logic              done_v;
  item_t             acc_item;
  item_t             done_item;
  item_t             out_item;
  logic              out_v;
  logic [XLEN:0]     acc_ext;
  logic [XLEN:0]     done_ext;

  always_comb begin
    stall   = (state_q == StWait) && !d_ack;
    accept  = mem_valid_i && !stall && !flush_i;
    is_load = (mem_opcode_i == OpLoad);
    // A load completes at acceptance only when IDLE and the memory answers at once; a load
    // accepted in the ack cycle of a previous load must wait for its own ack.
    load_defer = accept && is_load && !((state_q == StIdle) && d_ack);
    acc_v      = accept && !load_defer;
    done_v     = (state_q == StWait) && d_ack && !flush_i;

    acc_ext = load_extract(d_data_read, mem_res_i[OffW-1:0], mem_funct3_i);
    acc_item.addr = mem_rd_i;
    if (is_load) begin
      acc_item.mis  = acc_ext[XLEN];
      acc_item.data = acc_ext[XLEN-1:0];
    end else begin
      acc_item.mis  = 1'b0;
      if (mem_opcode_i == OpJal || mem_opcode_i == OpJalr) begin
        acc_item.data = mem_pc_i + PcStep;
      end else begin
        acc_item.data = mem_res_i;
      end
    end
    acc_item.we = !acc_item.mis && (mem_rd_i != '0);

    done_ext        = load_extract(d_data_read, ld_off_q, ld_f3_q);
    done_item.addr  = ld_rd_q;
    done_item.mis   = done_ext[XLEN];
    done_item.data  = done_ext[XLEN-1:0];
    done_item.we    = !done_ext[XLEN] && (ld_rd_q != '0);

    state_d = state_q;
    if (state_q == StWait && (flush_i || d_ack)) state_d = StIdle;
    if (load_defer) state_d = StWait;

    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    if (load_defer) begin
      ld_rd_d  = mem_rd_i;
      ld_f3_d  = mem_funct3_i;
      ld_off_d = mem_res_i[OffW-1:0];
    end

    // Oldest first: skid entry, then the completing load, then the new acceptance. The skid
    // is always empty in WAIT, so at most two items compete and one slot absorbs the spill.
    skid_d   = skid_q;
    skid_v_d = 1'b0;
    out_item = acc_item;
    out_v    = 1'b0;
    if (skid_v_q) begin
      out_item = skid_q;
      out_v    = 1'b1;
      if (done_v) begin
        skid_d   = done_item;
        skid_v_d = 1'b1;
      end else if (acc_v) begin
        skid_d   = acc_item;
        skid_v_d = 1'b1;
      end
    end else if (done_v) begin
      out_item = done_item;
      out_v    = 1'b1;
      if (acc_v) begin
        skid_d   = acc_item;
        skid_v_d = 1'b1;
      end
    end else if (acc_v) begin
      out_item = acc_item;
      out_v    = 1'b1;
    end

    rf_we_d    = out_v && out_item.we;
    misalign_d = out_v && out_item.mis;
    rf_waddr_d = out_v ? out_item.addr : rf_waddr_q;
    rf_wdata_d = out_v ? out_item.data : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      rf_we_q    <= rf_we_d;
      misalign_q <= misalign_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign wb_stall_o  = stall;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign misalign_o  = misalign_q;
  assign fwd_valid_o = rf_we_q;
  assign fwd_rd_o    = rf_waddr_q;
  assign fwd_data_o  = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  typedef struct {
    bit          is64;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] res;
    logic [63:0] pc;
    logic [63:0] data;
    bit          exp_we;
    bit          exp_mis;
    logic [63:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        flush;
  logic        ack;
  logic        valid32, valid64;
  logic [31:0] res32, pc32, data32;
  logic [63:0] res64, pc64, data64;

  logic        stall32, we32, mis32, fv32;
  logic [4:0]  waddr32, frd32;
  logic [31:0] wdata32, fdata32;
  logic        stall64, we64, mis64, fv64;
  logic [4:0]  waddr64, frd64;
  logic [63:0] wdata64, fdata64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage_reg #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .reset(reset), .mem_valid_i(valid32), .mem_opcode_i(op), .mem_funct3_i(f3),
    .mem_rd_i(rd), .mem_res_i(res32), .mem_pc_i(pc32), .flush_i(flush),
    .d_data_read(data32), .d_ack(ack), .wb_stall_o(stall32), .rf_we_o(we32),
    .rf_waddr_o(waddr32), .rf_wdata_o(wdata32), .misalign_o(mis32),
    .fwd_valid_o(fv32), .fwd_rd_o(frd32), .fwd_data_o(fdata32)
  );

  wb_stage_reg #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .reset(reset), .mem_valid_i(valid64), .mem_opcode_i(op), .mem_funct3_i(f3),
    .mem_rd_i(rd), .mem_res_i(res64), .mem_pc_i(pc64), .flush_i(flush),
    .d_data_read(data64), .d_ack(ack), .wb_stall_o(stall64), .rf_we_o(we64),
    .rf_waddr_o(waddr64), .rf_wdata_o(wdata64), .misalign_o(mis64),
    .fwd_valid_o(fv64), .fwd_rd_o(frd64), .fwd_data_o(fdata64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one instruction with an immediate ack, then check the write one cycle later.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag     = $sformatf("vec%0d", idx);
    op      = v.op;
    f3      = v.f3;
    rd      = v.rd;
    ack     = 1'b1;
    valid32 = !v.is64;
    valid64 = v.is64;
    res32   = v.res[31:0];
    pc32    = v.pc[31:0];
    data32  = v.data[31:0];
    res64   = v.res;
    pc64    = v.pc;
    data64  = v.data;
    @(negedge clk);
    valid32 = 1'b0;
    valid64 = 1'b0;
    ack     = 1'b0;
    if (v.is64) begin
      check({tag, " we"}, {63'd0, we64}, {63'd0, v.exp_we});
      check({tag, " mis"}, {63'd0, mis64}, {63'd0, v.exp_mis});
      if (v.exp_we) begin
        check({tag, " waddr"}, {59'd0, waddr64}, {59'd0, v.rd});
        check({tag, " wdata"}, wdata64, v.exp_data);
        check({tag, " fwd_data"}, fdata64, v.exp_data);
      end
    end else begin
      check({tag, " we"}, {63'd0, we32}, {63'd0, v.exp_we});
      check({tag, " mis"}, {63'd0, mis32}, {63'd0, v.exp_mis});
      if (v.exp_we) begin
        check({tag, " waddr"}, {59'd0, waddr32}, {59'd0, v.rd});
        check({tag, " wdata"}, {32'd0, wdata32}, v.exp_data);
        check({tag, " fwd_data"}, {32'd0, fdata32}, v.exp_data);
        check({tag, " fwd_valid"}, {63'd0, fv32}, 64'd1);
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, OpImm,   3'd0, 5'd5,  64'h1234,     64'h0,  64'h0,        1, 0, 64'h1234});
    vecs.push_back('{0, OpJal,   3'd0, 5'd1,  64'hDEAD,     64'h100, 64'h0,       1, 0, 64'h104});
    vecs.push_back('{0, OpJal,   3'd0, 5'd0,  64'hDEAD,     64'h100, 64'h0,       0, 0, 64'h0});
    vecs.push_back('{0, OpJalr,  3'd0, 5'd2,  64'h0,  64'hFFFF_FFFC,   64'h0,     1, 0, 64'h0});
    vecs.push_back('{0, OpAuipc, 3'd0, 5'd3,  64'h2000_0100, 64'h100, 64'h0,      1, 0,
                     64'h2000_0100});
    vecs.push_back('{0, OpLoad,  3'b000, 5'd4, 64'h1003, 64'h0, 64'h80FF_FF00,     1, 0,
                     64'hFFFF_FF80});
    vecs.push_back('{0, OpLoad,  3'b100, 5'd4, 64'h1003, 64'h0, 64'h80FF_FF00,     1, 0,
                     64'h0000_0080});
    vecs.push_back('{0, OpLoad,  3'b001, 5'd6, 64'h1002, 64'h0, 64'h80FF_FF00,     1, 0,
                     64'hFFFF_80FF});
    vecs.push_back('{0, OpLoad,  3'b101, 5'd6, 64'h1000, 64'h0, 64'h1234_8765,     1, 0,
                     64'h0000_8765});
    vecs.push_back('{0, OpLoad,  3'b001, 5'd6, 64'h1001, 64'h0, 64'h1234_8765,     0, 1, 64'h0});
    vecs.push_back('{0, OpLoad,  3'b010, 5'd7, 64'h1000, 64'h0, 64'hCAFE_BABE,     1, 0,
                     64'hCAFE_BABE});
    vecs.push_back('{0, OpLoad,  3'b010, 5'd7, 64'h1002, 64'h0, 64'hCAFE_BABE,     0, 1, 64'h0});
    vecs.push_back('{0, OpLoad,  3'b011, 5'd8, 64'h1004, 64'h0, 64'h1122_3344,     1, 0,
                     64'h1122_3344});
    vecs.push_back('{0, OpLoad,  3'b111, 5'd8, 64'h1001, 64'h0, 64'h1122_3344,     0, 1, 64'h0});
    vecs.push_back('{0, OpLoad,  3'b000, 5'd9, 64'h1001, 64'h0, 64'h80FF_FF00,     1, 0,
                     64'hFFFF_FFFF});
    vecs.push_back('{0, OpLoad,  3'b100, 5'd0, 64'h1001, 64'h0, 64'h80FF_FF00,     0, 0, 64'h0});
    vecs.push_back('{1, OpLoad,  3'b110, 5'd5, 64'h1004, 64'h0, 64'hFFFF_FFFF_0000_0000, 1, 0,
                     64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{1, OpLoad,  3'b010, 5'd5, 64'h1004, 64'h0, 64'hFFFF_FFFF_0000_0000, 1, 0,
                     64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{1, OpLoad,  3'b011, 5'd6, 64'h1000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0,
                     64'h0123_4567_89AB_CDEF});
    vecs.push_back('{1, OpLoad,  3'b011, 5'd6, 64'h1004, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1,
                     64'h0});
    vecs.push_back('{1, OpLoad,  3'b111, 5'd6, 64'h1000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0,
                     64'h0123_4567_89AB_CDEF});
    vecs.push_back('{1, OpLoad,  3'b000, 5'd7, 64'h1007, 64'h0, 64'h8000_0000_0000_0000, 1, 0,
                     64'hFFFF_FFFF_FFFF_FF80});
    vecs.push_back('{1, OpJal,   3'd0, 5'd1, 64'h0, 64'h1_0000_0000, 64'h0,           1, 0,
                     64'h1_0000_0004});

    reset = 1'b1; op = '0; f3 = '0; rd = '0; flush = 1'b0; ack = 1'b0;
    valid32 = 1'b0; valid64 = 1'b0;
    res32 = '0; pc32 = '0; data32 = '0; res64 = '0; pc64 = '0; data64 = '0;
    repeat (2) @(negedge clk);
    check("rst we", {63'd0, we32}, 64'd0);
    check("rst mis", {63'd0, mis32}, 64'd0);
    check("rst waddr", {59'd0, waddr32}, 64'd0);
    check("rst wdata", {32'd0, wdata32}, 64'd0);
    check("rst stall", {63'd0, stall32}, 64'd0);
    check("rst we64", {63'd0, we64}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);
    check("idle we", {63'd0, we32}, 64'd0);
    check("idle mis", {63'd0, mis32}, 64'd0);

    // Slow load: three stall cycles, then the write, then the ADD accepted on the ack cycle.
    op = OpLoad; f3 = 3'b010; rd = 5'd7; res32 = 32'h2000; valid32 = 1'b1; ack = 1'b0;
    @(negedge clk);
    op = OpReg; f3 = 3'b000; rd = 5'd8; res32 = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wait%0d stall", i), {63'd0, stall32}, 64'd1);
      check($sformatf("wait%0d we", i), {63'd0, we32}, 64'd0);
      @(negedge clk);
    end
    ack = 1'b1; data32 = 32'h0BAD_F00D;
    #1;
    check("ack stall", {63'd0, stall32}, 64'd0);
    @(negedge clk);
    valid32 = 1'b0; ack = 1'b0;
    check("slow ld we", {63'd0, we32}, 64'd1);
    check("slow ld waddr", {59'd0, waddr32}, 64'd7);
    check("slow ld wdata", {32'd0, wdata32}, 64'h0BAD_F00D);
    @(negedge clk);
    check("b2b add we", {63'd0, we32}, 64'd1);
    check("b2b add waddr", {59'd0, waddr32}, 64'd8);
    check("b2b add wdata", {32'd0, wdata32}, 64'h55);
    @(negedge clk);
    check("after b2b we", {63'd0, we32}, 64'd0);

    // Flush together with ack in WAIT: no write, back to IDLE.
    op = OpLoad; f3 = 3'b010; rd = 5'd9; res32 = 32'h3000; valid32 = 1'b1; ack = 1'b0;
    @(negedge clk);
    valid32 = 1'b0; flush = 1'b1; ack = 1'b1; data32 = 32'hDEAD_BEEF;
    @(negedge clk);
    flush = 1'b0; ack = 1'b0;
    #1;
    check("flush we", {63'd0, we32}, 64'd0);
    check("flush stall", {63'd0, stall32}, 64'd0);
    op = OpImm; f3 = 3'b000; rd = 5'd10; res32 = 32'h77; valid32 = 1'b1;
    @(negedge clk);
    valid32 = 1'b0;
    check("post flush we", {63'd0, we32}, 64'd1);
    check("post flush waddr", {59'd0, waddr32}, 64'd10);
    check("post flush wdata", {32'd0, wdata32}, 64'h77);

    // Reset in WAIT: outputs cleared and the late ack is ignored.
    op = OpLoad; f3 = 3'b010; rd = 5'd11; res32 = 32'h4000; valid32 = 1'b1; ack = 1'b0;
    @(negedge clk);
    valid32 = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ack = 1'b1; data32 = 32'h1234_5678;
    check("wait rst we", {63'd0, we32}, 64'd0);
    check("wait rst waddr", {59'd0, waddr32}, 64'd0);
    check("wait rst wdata", {32'd0, wdata32}, 64'd0);
    check("wait rst mis", {63'd0, mis32}, 64'd0);
    @(negedge clk);
    ack = 1'b0;
    check("wait rst no write", {63'd0, we32}, 64'd0);
    #1;
    check("wait rst stall", {63'd0, stall32}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
